// File: rtl/com_pkg.sv
// Shared definitions for the COM UART peripheral: register map, STATUS/IRQ_EN bit positions, TX FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package com_pkg;

    // Register addresses on the COM port
    localparam logic [7:0] ADDR_LED      = 8'h00;
    localparam logic [7:0] ADDR_SW       = 8'h01;
    localparam logic [7:0] ADDR_DATA     = 8'h02;
    localparam logic [7:0] ADDR_STATUS   = 8'h03;
    localparam logic [7:0] ADDR_RX_COUNT = 8'h04;
    localparam logic [7:0] ADDR_TX_COUNT = 8'h05;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h06;

    // STATUS register bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_IS_TX       = 5;
    localparam int ST_IS_RX       = 6;
    localparam int ST_TX_OVERFLOW = 7;

    // IRQ_EN bit positions
    localparam int IRQ_RX_NONEMPTY = 0;
    localparam int IRQ_TX_EMPTY    = 1;
    localparam int IRQ_ERR         = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/com_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on rd_data whenever not empty.
// Latency: push visible at head one cycle after the write edge; pop takes effect at the clock edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module com_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, no reset needed since reads are qualified by empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart.sv
// 8N1 UART engine: one start bit, 8 data bits LSB first, one stop bit; bit period 4*CLOCK_DIVIDE clocks.
// Latency: tx line drops at the edge that samples transmit; received pulses at mid stop bit.
// Backpressure: transmit ignored while is_transmitting; received is a single-cycle pulse with no hold-off.
module uart #(
    parameter int CLOCK_DIVIDE = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting
);
    localparam int BIT  = 4 * CLOCK_DIVIDE;
    localparam int HALF = 2 * CLOCK_DIVIDE;

    logic [15:0] tx_cnt;
    logic [3:0]  tx_left;
    logic [8:0]  tx_shift;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] rx_cnt;
    logic [3:0]  rx_bits;
    logic [7:0]  rx_shift;

    // Transmitter: start bit driven immediately, then nine shifts (eight data bits and the stop bit)
    always_ff @(posedge clk) begin
        if (rst) begin
            tx              <= 1'b1;
            is_transmitting <= 1'b0;
            tx_cnt          <= '0;
            tx_left         <= '0;
            tx_shift        <= '0;
        end else if (!is_transmitting) begin
            if (transmit) begin
                tx              <= 1'b0;
                tx_shift        <= {1'b1, tx_byte};
                tx_left         <= 4'd9;
                tx_cnt          <= 16'(BIT - 1);
                is_transmitting <= 1'b1;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 16'd1;
        end else if (tx_left == '0) begin
            is_transmitting <= 1'b0;
        end else begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[8:1]};
            tx_left  <= tx_left - 4'd1;
            tx_cnt   <= 16'(BIT - 1);
        end
    end

    // Two-flop synchroniser on the serial input, idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver: align to mid start bit, then sample once per bit period; bad start or stop drops the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            is_receiving <= 1'b0;
            received     <= 1'b0;
            rx_byte      <= '0;
            rx_cnt       <= '0;
            rx_bits      <= '0;
            rx_shift     <= '0;
        end else begin
            received <= 1'b0;
            if (!is_receiving) begin
                if (!rx_s) begin
                    is_receiving <= 1'b1;
                    rx_cnt       <= 16'(HALF - 1);
                    rx_bits      <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= 16'(BIT - 1);
                if (rx_bits == 4'd0) begin
                    if (rx_s) is_receiving <= 1'b0;
                    else      rx_bits      <= 4'd1;
                end else if (rx_bits <= 4'd8) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_bits  <= rx_bits + 4'd1;
                end else begin
                    is_receiving <= 1'b0;
                    if (rx_s) begin
                        received <= 1'b1;
                        rx_byte  <= rx_shift;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/com_uart_block.sv
// Memory-mapped COM peripheral: LED/switch registers plus UART with TX/RX FIFOs, status, sticky errors and IRQ.
// Latency: register reads are combinational; writes, pops and irq take effect at the next clk edge.
// Backpressure: DATA write to a full TX FIFO drops the byte (tx_overflow); RX arrival on a full FIFO drops it (rx_overrun).
module com_uart_block
    import com_pkg::*;
#(
    parameter int CLOCK_DIVIDE = 26,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int LED_WIDTH    = 8,
    parameter int SW_WIDTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           addr,
    input  logic [7:0]           wr_data,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [7:0]           rd_data,
    output logic                 irq,
    output logic [LED_WIDTH-1:0] leds,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic                 uart0_tx,
    input  logic                 uart0_rx
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]          tx_head;
    logic [TX_CW-1:0]    tx_count;
    logic                tx_full;
    logic                tx_empty;
    logic                tx_push;
    logic                tx_pop;
    logic [7:0]          rx_head;
    logic [RX_CW-1:0]    rx_count;
    logic                rx_full;
    logic                rx_empty;
    logic                rx_pop;
    logic                received;
    logic [7:0]          rx_byte;
    logic                is_transmitting;
    logic                is_receiving;
    logic                transmit;
    logic                uart_rst;
    logic                data_wr;
    logic                rx_drop;
    logic                rx_overrun;
    logic                tx_overflow;
    logic [2:0]          irq_en;
    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_sync;
    logic [7:0]          status;
    tx_state_t           state;
    tx_state_t           state_nxt;

    assign uart_rst = !rst;
    assign data_wr  = wr_en && (addr == ADDR_DATA);
    assign tx_push  = data_wr && !tx_full;
    assign rx_pop   = rd_en && (addr == ADDR_DATA);
    // A pop on the same edge frees the slot, so the arriving byte is only lost if nothing leaves
    assign rx_drop  = received && rx_full && !(rx_pop && !rx_empty);

    com_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_push),
        .pop     (tx_pop),
        .wr_data (wr_data),
        .rd_data (tx_head),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    com_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (received),
        .pop     (rx_pop),
        .wr_data (rx_byte),
        .rd_data (rx_head),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // The engine captures tx_byte on the same edge that sees transmit, so the FIFO head feeds it directly
    uart #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_uart (
        .clk             (clk),
        .rst             (uart_rst),
        .rx              (uart0_rx),
        .tx              (uart0_tx),
        .transmit        (transmit),
        .tx_byte         (tx_head),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_receiving    (is_receiving),
        .is_transmitting (is_transmitting)
    );

    // TX FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // TX FSM next state: launch a frame from the FIFO head, then track the engine through its busy window
    always_comb begin
        state_nxt = state;
        transmit  = 1'b0;
        tx_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && !is_transmitting) begin
                    transmit  = 1'b1;
                    tx_pop    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:  if (is_transmitting)  state_nxt = BUSY;
            BUSY:    if (!is_transmitting) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers, sticky error flags (a new error wins over a same-cycle clear) and switch sync
    always_ff @(posedge clk) begin
        if (!rst) begin
            leds        <= '0;
            irq_en      <= '0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            sw_meta     <= '0;
            sw_sync     <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (wr_en && (addr == ADDR_LED))    leds   <= wr_data[LED_WIDTH-1:0];
            if (wr_en && (addr == ADDR_IRQ_EN)) irq_en <= wr_data[2:0];
            if (rx_drop)
                rx_overrun <= 1'b1;
            else if (wr_en && (addr == ADDR_STATUS) && wr_data[ST_RX_OVERRUN])
                rx_overrun <= 1'b0;
            if (data_wr && tx_full)
                tx_overflow <= 1'b1;
            else if (wr_en && (addr == ADDR_STATUS) && wr_data[ST_TX_OVERFLOW])
                tx_overflow <= 1'b0;
        end
    end

    // Interrupt request, one cycle behind the conditions it reflects
    always_ff @(posedge clk) begin
        if (!rst) irq <= 1'b0;
        else      irq <= |(irq_en & {rx_overrun | tx_overflow, tx_empty, !rx_empty});
    end

    // Status vector and combinational read mux
    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_RX_OVERRUN]  = rx_overrun;
        status[ST_IS_TX]       = is_transmitting;
        status[ST_IS_RX]       = is_receiving;
        status[ST_TX_OVERFLOW] = tx_overflow;

        rd_data = '0;
        case (addr)
            ADDR_LED:      rd_data[LED_WIDTH-1:0] = leds;
            ADDR_SW:       rd_data[SW_WIDTH-1:0]  = sw_sync;
            ADDR_DATA:     rd_data = rx_empty ? 8'h00 : rx_head;
            ADDR_STATUS:   rd_data = status;
            ADDR_RX_COUNT: rd_data[RX_CW-1:0] = rx_count;
            ADDR_TX_COUNT: rd_data[TX_CW-1:0] = tx_count;
            ADDR_IRQ_EN:   rd_data[2:0] = irq_en;
            default:       rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_com_uart_block.sv
// Directed-plus-random bench for com_uart_block with queue-based reference model and serial line monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_com_uart_block;
    localparam int BIT = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       irq;
    logic [7:0] leds;
    logic [3:0] switches = 4'h0;
    logic       uart0_tx;
    logic       uart0_rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] tx_seen[$];
    int         tx_start[$];
    logic [7:0] rx_model[$];
    logic [7:0] tx_model[$];
    logic       rx_ovr_model;

    com_uart_block dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .irq      (irq),
        .leds     (leds),
        .switches (switches),
        .uart0_tx (uart0_tx),
        .uart0_rx (uart0_rx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        #1 d = rd_data;
    endtask

    task automatic pop(output logic [7:0] d);
        addr = 8'h02; rd_en = 1'b1;
        #1 d = rd_data;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Drive one 8N1 frame plus an idle bit, and account for it in the RX model
    task automatic send_frame(input logic [7:0] b);
        uart0_rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            uart0_rx = b[i];
            step(BIT);
        end
        uart0_rx = 1'b1;
        step(2 * BIT);
        if (rx_model.size() < 16) rx_model.push_back(b);
        else rx_ovr_model = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_seen.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk("tx_frame_count", tx_seen.size(), n);
    endtask

    // Serial line monitor: decodes frames on uart0_tx at mid-bit and logs their start times
    initial begin
        logic [7:0] b;
        int st;
        forever begin
            @(negedge clk);
            if (uart0_tx === 1'b0) begin
                st = cyc;
                repeat (BIT / 2) @(negedge clk);
                if (uart0_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT) @(negedge clk);
                        b[i] = uart0_tx;
                    end
                    repeat (BIT) @(negedge clk);
                    chk("tx_stop_bit", uart0_tx, 1'b1);
                    tx_seen.push_back(b);
                    tx_start.push_back(st);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] bytes[18];
        int gap;
        logic stayed_high;
        rx_ovr_model = 1'b0;

        // Reset held for two edges, then released
        @(negedge clk);
        step(1);
        rst = 1'b1;
        chk("rst_leds", leds, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_tx_idle", uart0_tx, 1'b1);
        peek(8'h03, d); chk("rst_status", d, 8'h04);
        peek(8'h04, d); chk("rst_rx_count", d, 8'h00);
        peek(8'h05, d); chk("rst_tx_count", d, 8'h00);

        // LED, switches, unmapped address, IRQ_EN readback
        wr(8'h00, 8'hA5);
        chk("leds_after_write", leds, 8'hA5);
        peek(8'h00, d); chk("led_readback", d, 8'hA5);
        switches = 4'b1010;
        step(1);
        peek(8'h01, d); chk("sw_sync_one_cycle", d, 8'h00);
        step(1);
        peek(8'h01, d); chk("sw_sync_two_cycles", d, 8'h0A);
        wr(8'h07, 8'h3C);
        peek(8'h07, d); chk("unmapped_read", d, 8'h00);
        chk("unmapped_write_no_led", leds, 8'hA5);
        wr(8'h06, 8'hFF);
        peek(8'h06, d); chk("irq_en_readback", d, 8'h07);
        step(1);
        chk("irq_tx_empty", irq, 1'b1);
        wr(8'h06, 8'h00);
        step(1);
        chk("irq_masked", irq, 1'b0);

        // Two back-to-back frames: content, gap and status while busy
        tx_seen.delete(); tx_start.delete();
        wr(8'h02, 8'h55);
        wr(8'h02, 8'h0F);
        step(10);
        peek(8'h03, d); chk("status_busy_one_queued", d, 8'h20);
        peek(8'h05, d); chk("tx_count_one", d, 8'h01);
        wait_tx(2, 3000);
        if (tx_seen.size() >= 2) begin
            chk("tx_byte0", tx_seen[0], 8'h55);
            chk("tx_byte1", tx_seen[1], 8'h0F);
            gap = tx_start[1] - tx_start[0];
            chk("tx_frame_spacing", (gap >= 10 * BIT && gap <= 10 * BIT + 2), 1'b1);
        end
        step(60);
        peek(8'h03, d); chk("status_tx_done", d, 8'h04);

        // Overfill the TX FIFO with random bytes
        tx_seen.delete(); tx_start.delete(); tx_model.delete();
        for (int i = 0; i < 18; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 18; i++) begin
            wr(8'h02, bytes[i]);
            if (i < 17) tx_model.push_back(bytes[i]);
        end
        peek(8'h05, d); chk("tx_count_full", d, 8'd16);
        peek(8'h03, d); chk("status_overflow_full", d, 8'hA8);
        wr(8'h06, 8'h04);
        step(1);
        chk("irq_err", irq, 1'b1);
        wr(8'h03, 8'h80);
        step(1);
        chk("irq_err_cleared", irq, 1'b0);
        peek(8'h03, d); chk("status_overflow_clear", d, 8'h28);
        wr(8'h06, 8'h00);
        wait_tx(17, 19000);
        for (int i = 0; i < 17; i++) begin
            if (i < tx_seen.size()) chk("tx_burst_byte", tx_seen[i], tx_model[i]);
        end
        step(60);
        peek(8'h03, d); chk("status_burst_done", d, 8'h04);

        // Receive three frames with rx_nonempty interrupt
        wr(8'h06, 8'h01);
        step(2);
        chk("irq_rx_idle", irq, 1'b0);
        send_frame(8'h31);
        send_frame(8'h32);
        send_frame(8'h33);
        chk("irq_rx", irq, 1'b1);
        peek(8'h04, d); chk("rx_count_three", d, 8'd3);
        peek(8'h03, d); chk("status_rx_three", d, 8'h05);
        for (int i = 0; i < 3; i++) begin
            pop(d);
            chk("rx_pop_byte", d, rx_model.pop_front());
        end
        step(2);
        chk("irq_rx_drained", irq, 1'b0);
        pop(d); chk("rx_pop_empty", d, 8'h00);
        peek(8'h04, d); chk("rx_count_empty", d, 8'd0);
        peek(8'h03, d); chk("status_after_empty_pop", d, 8'h04);
        wr(8'h06, 8'h00);

        // Overrun with 17 random frames
        for (int i = 0; i < 17; i++) send_frame(8'($urandom_range(0, 255)));
        peek(8'h04, d); chk("rx_count_full", d, rx_model.size());
        peek(8'h03, d); chk("status_overrun", d, {3'b000, rx_ovr_model, 4'b0111});
        while (rx_model.size() > 0) begin
            pop(d);
            chk("rx_overrun_byte", d, rx_model.pop_front());
        end
        peek(8'h04, d); chk("rx_count_drained", d, 8'd0);
        peek(8'h03, d); chk("status_overrun_sticky", d, 8'h14);
        wr(8'h03, 8'h10);
        peek(8'h03, d); chk("status_overrun_clear", d, 8'h04);

        // Reset in the middle of a TX frame with both FIFOs occupied
        send_frame(8'h5A);
        peek(8'h04, d); chk("rx_count_before_reset", d, 8'd1);
        wr(8'h02, 8'h00);
        wr(8'h02, 8'h11);
        wr(8'h02, 8'h22);
        step(300);
        chk("tx_midframe_low", uart0_tx, 1'b0);
        peek(8'h05, d); chk("tx_count_before_reset", d, 8'd2);
        rst = 1'b0;
        step(1);
        chk("tx_high_after_reset", uart0_tx, 1'b1);
        step(1);
        peek(8'h05, d); chk("tx_count_flushed", d, 8'd0);
        peek(8'h04, d); chk("rx_count_flushed", d, 8'd0);
        chk("leds_reset", leds, 8'h00);
        rst = 1'b1;
        step(1);
        peek(8'h03, d); chk("status_after_reset", d, 8'h04);
        chk("irq_after_reset", irq, 1'b0);
        stayed_high = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if (uart0_tx !== 1'b1) stayed_high = 1'b0;
        end
        chk("tx_stays_idle", stayed_high, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
